// File: rtl/udp_buf_pkg.sv
// Shared types and constants for the UDP payload buffer.
package udp_buf_pkg;

  localparam int unsigned LEN_W      = 16;
  // Cycles between presenting a RAM address and its data being valid.
  localparam int unsigned RAM_RD_LAT = 1;

  typedef enum logic [2:0] {
    W_IDLE,
    W_CHECK,
    W_COPY,
    W_WAIT,
    W_DROP,
    W_DONE
  } wr_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_SEND,
    R_FIN
  } rd_state_t;

endpackage

// File: rtl/pkt_len_fifo.sv
// Synchronous FIFO of queued packet lengths with full/empty/count flags.
module pkt_len_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  assign full    = (cnt_q == (PW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rp_q];
  assign count   = cnt_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push_ok) wp_d = wp_q + 1'b1;
    if (pop_ok)  rp_d = rp_q + 1'b1;
    if (push_ok && !pop_ok)      cnt_d = cnt_q + 1'b1;
    else if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are only ever read below cnt_q, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q] <= push_data;
  end

endmodule

// File: rtl/udp_pkt_buffer.sv
// Multi-packet UDP payload buffer: copies RX RAM payloads into a circular
// byte buffer and replays them, in order, to the MAC TX payload path.
module udp_pkt_buffer
  import udp_buf_pkg::*;
#(
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned PKT_DEPTH = 4,
  parameter int unsigned MAX_LEN   = 1472,
  parameter bit          DROP_MODE = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_fs,
  output logic                         rx_fd,
  input  logic [15:0]                  rx_len,
  output logic [ADDR_W-1:0]            rx_addr,
  input  logic [7:0]                   rx_data,
  output logic                         tx_fs,
  output logic [15:0]                  tx_len,
  input  logic                         tx_prep,
  input  logic                         tx_req,
  output logic                         tx_en,
  output logic [7:0]                   tx_data,
  input  logic                         tx_fd,
  output logic [$clog2(PKT_DEPTH):0]   pkt_cnt,
  output logic [15:0]                  drop_cnt
);
  localparam int unsigned BUF_BYTES = 1 << ADDR_W;
  localparam int unsigned UW        = ADDR_W + 1;

  wr_state_t               wst_q, wst_d;
  logic [LEN_W-1:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]       rx_addr_q, rx_addr_d, wr_ptr_q, wr_ptr_d;
  logic                    iss_q, iss_d, rx_fd_q, rx_fd_d;
  logic [RAM_RD_LAT-1:0]   cap_q, cap_d;
  logic [15:0]             drop_q, drop_d;
  logic [UW-1:0]           used_q, used_d, free_bytes;

  rd_state_t               rst_st_q, rst_st_d;
  logic [ADDR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]        riss_q, riss_d, rsent_q, rsent_d, tx_len_q, tx_len_d;
  logic                    tx_fs_q, tx_fs_d, tx_en_q, tx_en_d;
  logic [7:0]              tx_data_q, tx_data_d;

  logic                    len_bad, no_room, rsv_en, rel_en, ram_we, ram_re;
  logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LEN_W-1:0]        fifo_head;
  logic [7:0]              buf_mem [BUF_BYTES];
  logic [7:0]              ram_dout;
  logic                    unused_tx_prep;

  assign unused_tx_prep = tx_prep;
  assign free_bytes     = UW'(BUF_BYTES) - used_q;
  assign len_bad        = (wlen_q == '0) || (32'(wlen_q) > MAX_LEN);
  assign no_room        = (32'(free_bytes) < 32'(wlen_q)) || fifo_full;

  // Write side: admit, copy from RX RAM, or drop one packet per rx_fs level.
  always_comb begin
    wst_d     = wst_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    rx_addr_d = rx_addr_q;
    iss_d     = iss_q;
    cap_d     = '0;
    wr_ptr_d  = wr_ptr_q;
    rx_fd_d   = 1'b0;
    drop_d    = drop_q;
    rsv_en    = 1'b0;
    fifo_push = 1'b0;
    ram_we    = 1'b0;
    unique case (wst_q)
      W_IDLE: if (rx_fs) begin
        wlen_d = rx_len;
        wst_d  = W_CHECK;
      end
      W_CHECK, W_WAIT: begin
        if (len_bad) wst_d = W_DROP;
        else if (no_room) wst_d = DROP_MODE ? W_DROP : W_WAIT;
        else begin
          rsv_en    = 1'b1;
          rx_addr_d = '0;
          iss_d     = 1'b1;
          wcnt_d    = '0;
          wst_d     = W_COPY;
        end
      end
      W_COPY: begin
        // cap_q tracks which presented addresses have data on rx_data now.
        cap_d = RAM_RD_LAT'({cap_q, iss_q});
        if (iss_q) begin
          if (LEN_W'(rx_addr_q) + LEN_W'(1) < wlen_q) rx_addr_d = rx_addr_q + 1'b1;
          else begin
            iss_d     = 1'b0;
            rx_addr_d = '0;
          end
        end
        if (cap_q[RAM_RD_LAT-1]) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          wcnt_d   = wcnt_q + LEN_W'(1);
          if (wcnt_q + LEN_W'(1) == wlen_q) begin
            fifo_push = 1'b1;
            rx_fd_d   = 1'b1;
            wst_d     = W_DONE;
          end
        end
      end
      W_DROP: begin
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        rx_fd_d = 1'b1;
        wst_d   = W_DONE;
      end
      W_DONE: if (!rx_fs) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  // Read side: present head packet, stream it on request, retire on tx_fd.
  always_comb begin
    rst_st_d  = rst_st_q;
    rd_ptr_d  = rd_ptr_q;
    riss_d    = riss_q;
    rsent_d   = rsent_q;
    tx_fs_d   = tx_fs_q;
    tx_len_d  = tx_len_q;
    tx_en_d   = 1'b0;
    tx_data_d = '0;
    ram_re    = 1'b0;
    fifo_pop  = 1'b0;
    rel_en    = 1'b0;
    unique case (rst_st_q)
      R_IDLE: if (!fifo_empty) begin
        tx_fs_d  = 1'b1;
        tx_len_d = fifo_head;
        rst_st_d = R_WAIT;
      end
      R_WAIT: if (tx_req) begin
        ram_re   = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        riss_d   = LEN_W'(1);
        rsent_d  = '0;
        rst_st_d = R_SEND;
      end
      R_SEND: begin
        tx_en_d   = 1'b1;
        tx_data_d = ram_dout;
        rsent_d   = rsent_q + LEN_W'(1);
        if (riss_q < tx_len_q) begin
          ram_re   = 1'b1;
          rd_ptr_d = rd_ptr_q + 1'b1;
          riss_d   = riss_q + LEN_W'(1);
        end
        if (rsent_q + LEN_W'(1) == tx_len_q) rst_st_d = R_FIN;
      end
      R_FIN: if (tx_fd) begin
        tx_fs_d  = 1'b0;
        tx_len_d = '0;
        fifo_pop = 1'b1;
        rel_en   = 1'b1;
        rst_st_d = R_IDLE;
      end
      default: rst_st_d = R_IDLE;
    endcase
  end

  // Reservation and release may land in the same cycle.
  always_comb begin
    used_d = used_q + (rsv_en ? UW'(wlen_q) : UW'(0)) - (rel_en ? UW'(tx_len_q) : UW'(0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wst_q     <= W_IDLE;
      wlen_q    <= '0;
      wcnt_q    <= '0;
      rx_addr_q <= '0;
      iss_q     <= 1'b0;
      cap_q     <= '0;
      wr_ptr_q  <= '0;
      rx_fd_q   <= 1'b0;
      drop_q    <= '0;
      used_q    <= '0;
      rst_st_q  <= R_IDLE;
      rd_ptr_q  <= '0;
      riss_q    <= '0;
      rsent_q   <= '0;
      tx_fs_q   <= 1'b0;
      tx_len_q  <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
    end else begin
      wst_q     <= wst_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      rx_addr_q <= rx_addr_d;
      iss_q     <= iss_d;
      cap_q     <= cap_d;
      wr_ptr_q  <= wr_ptr_d;
      rx_fd_q   <= rx_fd_d;
      drop_q    <= drop_d;
      used_q    <= used_d;
      rst_st_q  <= rst_st_d;
      rd_ptr_q  <= rd_ptr_d;
      riss_q    <= riss_d;
      rsent_q   <= rsent_d;
      tx_fs_q   <= tx_fs_d;
      tx_len_q  <= tx_len_d;
      tx_en_q   <= tx_en_d;
      tx_data_q <= tx_data_d;
    end
  end

  // Simple dual-port byte buffer with registered read.
  always_ff @(posedge clk) begin
    if (ram_we) buf_mem[wr_ptr_q] <= rx_data;
    if (ram_re) ram_dout <= buf_mem[rd_ptr_q];
  end

  pkt_len_fifo #(
    .DEPTH (PKT_DEPTH),
    .W     (LEN_W)
  ) u_len_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (wlen_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (pkt_cnt)
  );

  assign rx_fd    = rx_fd_q;
  assign rx_addr  = rx_addr_q;
  assign drop_cnt = drop_q;
  assign tx_fs    = tx_fs_q;
  assign tx_len   = tx_len_q;
  assign tx_en    = tx_en_q;
  assign tx_data  = tx_data_q;

endmodule

// File: doc/udp_pkt_buffer.md
Name: udp_pkt_buffer

Overview:
- Multi-packet UDP payload buffer between MAC RX payload RAM and MAC TX payload path, all in one clock domain (gmii clock at integration).
- Copies each received payload into a circular byte buffer, queues up to PKT_DEPTH packet lengths, and replays each packet to the TX side using the fs/fd + prep/req handshake.
- Successor to the single-shot RX→FIFO→TX path: parametrised depth, multi-packet queuing, length checks, drop/stall mode, statistics.

Parameters:
- ADDR_W, 11, log2 of byte-buffer depth (2048 bytes).
- PKT_DEPTH, 4, length-FIFO entries (power of 2, ≥2).
- MAX_LEN, 1472, largest accepted payload in bytes (must be ≤ 2^ADDR_W).
- DROP_MODE, 1, 1 = drop a packet that does not fit; 0 = stall RX until it fits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- rx_fs  in  1  level: MAC has a payload ready in its RX RAM
- rx_fd  out  1  one-cycle pulse: payload consumed or dropped
- rx_len  in  16  payload length, valid while rx_fs=1
- rx_addr  out  11  RX RAM byte address
- rx_data  in  8  RX RAM data, valid 1 cycle after rx_addr
- tx_fs  out  1  level: a packet is queued for transmit
- tx_len  out  16  length of head packet, stable while tx_fs=1
- tx_prep  in  1  MAC is building headers (informational; ignored while idle)
- tx_req  in  1  one-cycle pulse: MAC requests payload bytes
- tx_en  out  1  payload byte strobe
- tx_data  out  8  payload byte
- tx_fd  in  1  one-cycle pulse: MAC finished the frame
- pkt_cnt  out  $clog2(PKT_DEPTH)+1  queued packets
- drop_cnt  out  16  saturating count of dropped packets

Behaviour:
- Reset: all outputs 0; pointers, used-byte count, length FIFO and both FSMs cleared. Reset mid-packet abandons it; no rx_fd is issued.
- Write FSM: W_IDLE → W_CHECK → (W_COPY | W_WAIT | W_DROP) → W_DONE → W_IDLE.
  - W_IDLE: rx_fs=1 → latch rx_len → W_CHECK.
  - W_CHECK: rx_len==0 or >MAX_LEN → W_DROP regardless of mode.
  - Packet does not fit (free bytes < len, or length FIFO full): DROP_MODE=1 → W_DROP; DROP_MODE=0 → W_WAIT (re-check every cycle).
  - Packet fits: used += len (reservation) → W_COPY.
  - W_COPY: rx_addr = 0..len-1, one per cycle. Capture rx_data one cycle later; write at wr_ptr, wr_ptr wraps mod 2^ADDR_W.
  - After the last write, push len to the length FIFO → W_DONE.
  - W_DROP: drop_cnt +1 (saturate at 0xFFFF) → W_DONE.
  - W_DONE: rx_fd=1 for exactly one cycle. Wait for rx_fs=0 before W_IDLE, so a held level is never double-counted.
- Read FSM: R_IDLE → R_WAIT → R_SEND → R_FIN → R_IDLE.
  - R_IDLE: length FIFO non-empty → tx_len = head, tx_fs=1 → R_WAIT.
  - R_WAIT: on tx_req → issue first buffer read → R_SEND. tx_req in any other state is ignored.
  - R_SEND: tx_en rises 2 cycles after the tx_req cycle. It stays high for exactly tx_len consecutive cycles with bytes in write order. rd_ptr advances per byte and wraps.
  - R_FIN: wait for tx_fd. Then tx_fs=0, pop the FIFO, used -= len → R_IDLE. The next packet's tx_fs may assert on the following cycle.
- Used-byte count: a same-cycle reserve and release applies both deltas. Used never exceeds 2^ADDR_W.
- Length FIFO: a same-cycle push and pop leaves pkt_cnt unchanged. Push while full cannot occur (checked in W_CHECK).
- tx_len/tx_data are 0 when tx_fs/tx_en are low.

Decomposition:
- Package udp_buf_pkg: FSM state enums, LEN_W=16, RAM read latency constant.
- Sub-module pkt_len_fifo: synchronous PKT_DEPTH×16 FIFO with full/empty/count.
- Byte buffer: inferred simple dual-port RAM inside the top module.

Test Plan:
- Single packet, rx_len=64, bytes 0x00..0x3F → one rx_fd pulse. tx_fs=1 with tx_len=64. After tx_req, tx_en high exactly 64 cycles starting 2 cycles later, data 0x00..0x3F. After tx_fd, pkt_cnt=0.
- Four packets of lengths 10, 20, 30, 40 with no tx_req → pkt_cnt=4. Fifth packet, DROP_MODE=1 → dropped, rx_fd pulses, drop_cnt=1. Drain → lengths and data in order.
- rx_len=0 and rx_len=1473 → both dropped, drop_cnt=2, nothing queued, no tx_fs.
- Wrap-around: ADDR_W=11, send three 1000-byte packets, draining each → third packet crosses address 2047→0 and reads back byte-exact.
- DROP_MODE=0, buffer holding 1500 bytes, new 600-byte packet → rx_fd stays low until the head packet's tx_fd frees space. Then the copy proceeds, drop_cnt=0.
- Assert rst during W_COPY and R_SEND → all outputs 0 next cycle, pkt_cnt=0. The next fresh packet passes end-to-end correctly.
